// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared opcodes, FSM states and IR field positions for seq_datapath
//
// Purpose: common definitions imported by seq_datapath and seq_alu.
// Contents: opcode localparams, instruction field bit positions, the
//           sequencer state enum and an opcode-legality helper.
package datapath_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHL = 5'b00111;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  typedef enum logic [2:0] {
    IDLE,
    LD_B,
    T1,
    T2,
    T3,
    T4
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - combinational ALU for the sequenced datapath
//
// Purpose: result = op(a, b), arithmetic modulo 2^DATA_W, no flags.
// Ports:
//   op      in   5       opcode (IR[31:27])
//   a       in   DATA_W  first operand (Y register)
//   b       in   DATA_W  second operand (R[rc]); low $clog2(DATA_W) bits are the SHL amount
//   result  out  DATA_W  ALU result, 0 for opcodes outside the table
module seq_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SHL:  result = a << b[SH_W-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/seq_datapath.sv
// rtl/seq_datapath.sv - register-file datapath with a T0..T4 micro-sequencer
//
// Purpose: N x W register file plus MDR/IR/Y/Z staging registers. Register
//          loads and 3-register ALU instructions arrive over valid/ready
//          handshakes and are sequenced by an internal FSM.
// Build option: define R0_ZERO_EN to make R0 read as zero and drop writes to it.
// Ports:
//   clock        in   1       system clock, rising edge
//   clear        in   1       asynchronous active-low reset
//   ld_valid     in   1       register-load request
//   ld_ready     out  1       high in IDLE
//   ld_reg       in   REG_AW  load destination index
//   ld_data      in   DATA_W  load value
//   instr_valid  in   1       instruction request
//   instr_ready  out  1       high in IDLE
//   instr        in   32      [31:27]=op [26:23]=ra [22:19]=rb [18:15]=rc
//   done         out  1       one-cycle pulse after the result write
//   err          out  1       one-cycle pulse on a rejected instruction or load
//   busy         out  1       high outside IDLE
//   rd_reg       in   REG_AW  debug read index
//   rd_data      out  DATA_W  registered R[rd_reg]
module seq_datapath
  import datapath_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              done,
  output logic              err,
  output logic              busy,
  input  logic [REG_AW-1:0] rd_reg,
  output logic [DATA_W-1:0] rd_data
);

  // MDR carries both load data and whole instructions, so it is never narrower than 32.
  localparam int         MDR_W = (DATA_W > 32) ? DATA_W : 32;
  localparam logic [4:0] NREGS = 5'(NUM_REGS);

  state_t            state, state_nx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [MDR_W-1:0]  mdr;
  logic [31:15]      ir;
  logic [DATA_W-1:0] y, z;
  logic [REG_AW-1:0] ld_idx;

  logic [4:0]        op;
  logic [3:0]        ra, rb, rc;
  logic              illegal;
  logic [DATA_W-1:0] rb_data, rc_data, alu_res;
  logic              wr_en;
  logic [3:0]        wr_idx;
  logic [DATA_W-1:0] wr_val;

  function automatic logic idx_ok(input logic [3:0] idx);
    return {1'b0, idx} < NREGS;
  endfunction

  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (idx_ok(idx)) v = regs[idx[REG_AW-1:0]];
`ifdef R0_ZERO_EN
    if (idx == 4'd0) v = '0;
`endif
    return v;
  endfunction

  assign op          = ir[OP_HI:OP_LO];
  assign ra          = ir[RA_HI:RA_LO];
  assign rb          = ir[RB_HI:RB_LO];
  assign rc          = ir[RC_HI:RC_LO];
  assign illegal     = !op_legal(op) || !idx_ok(ra) || !idx_ok(rb) || !idx_ok(rc);
  assign rb_data     = rf_read(rb);
  assign rc_data     = rf_read(rc);

  assign ld_ready    = (state == IDLE);
  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (y),
    .b      (rc_data),
    .result (alu_res)
  );

  // Single register-file write port shared by LD_B and T4; out-of-range
  // (and, with R0_ZERO_EN, R0) destinations are silently dropped.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    wr_val = '0;
    case (state)
      LD_B: begin
        wr_en  = 1'b1;
        wr_idx = 4'(ld_idx);
        wr_val = mdr[DATA_W-1:0];
      end
      T4: begin
        wr_en  = 1'b1;
        wr_idx = ra;
        wr_val = z;
      end
      default: ;
    endcase
    if (!idx_ok(wr_idx)) wr_en = 1'b0;
`ifdef R0_ZERO_EN
    if (wr_idx == 4'd0) wr_en = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nx;
  end

  // Load has priority over an instruction offered in the same IDLE cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ld_valid)         state_nx = LD_B;
        else if (instr_valid) state_nx = T1;
      end
      LD_B:    state_nx = IDLE;
      T1:      state_nx = T2;
      T2:      state_nx = illegal ? IDLE : T3;
      T3:      state_nx = T4;
      T4:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      mdr     <= '0;
      ir      <= '0;
      y       <= '0;
      z       <= '0;
      ld_idx  <= '0;
      rd_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= (state == T4);
      err     <= ((state == T2) && illegal) || ((state == LD_B) && !idx_ok(4'(ld_idx)));
      rd_data <= rf_read(4'(rd_reg));
      if (wr_en) regs[wr_idx[REG_AW-1:0]] <= wr_val;
      case (state)
        IDLE: begin
          if (ld_valid) begin
            mdr    <= MDR_W'(ld_data);
            ld_idx <= ld_reg;
          end else if (instr_valid) begin
            mdr    <= MDR_W'(instr);
          end
        end
        T1:      ir <= mdr[31:15];
        T2:      y  <= rb_data;
        T3:      z  <= alu_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// tb/tb_seq_datapath.sv - randomized self-checking bench for seq_datapath
module tb_seq_datapath;

  localparam int DW = 32;
  localparam int NR = 12;
  localparam int AW = $clog2(NR);

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          ld_valid, ld_ready, instr_valid, instr_ready;
  logic [AW-1:0] ld_reg, rd_reg;
  logic [DW-1:0] ld_data, rd_data;
  logic [31:0]   instr;
  logic          done, err, busy;

  always #5 clock = ~clock;

  seq_datapath #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clock(clock), .clear(clear),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .done(done), .err(err), .busy(busy),
    .rd_reg(rd_reg), .rd_data(rd_data)
  );

  int checks = 0;
  int failures = 0;

  // Model: register contents after the latest edge, plus the expected
  // timeline (edge numbers) of the single transaction in flight.
  int            cyc = 0;
  int            busy_lo = 1, busy_hi = 0, done_cyc = -1, err_cyc = -1;
  int            wr_cyc = -1, wr_idx = 0;
  logic [DW-1:0] wr_val;
  logic [DW-1:0] m_regs [16];
  logic [DW-1:0] rd_exp = '0;
  bit            hold_rd = 0;
  bit            r0z;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] m_read(input int idx);
    if (idx >= NR) return '0;
    if (r0z && idx == 0) return '0;
    return m_regs[idx];
  endfunction

  function automatic logic [DW-1:0] m_alu(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      5'd3:    return a + b;
      5'd4:    return a - b;
      5'd5:    return a & b;
      5'd6:    return a | b;
      5'd7:    return a << b[4:0];
      default: return '0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (!clear) begin
      rd_exp = '0;
      foreach (m_regs[i]) m_regs[i] = '0;
    end else begin
      rd_exp = m_read(int'(rd_reg));
      cyc++;
      if (cyc == wr_cyc && wr_idx < NR && !(r0z && wr_idx == 0)) m_regs[wr_idx] = wr_val;
    end
  end

  always @(posedge clock) begin
    bit eb;
    #2;
    if (!clear) begin
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_ld_ready", ld_ready, 1);
      check("rst_instr_ready", instr_ready, 1);
      check("rst_rd_data", rd_data, 0);
    end else begin
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      check("done", done, (cyc == done_cyc));
      check("err", err, (cyc == err_cyc));
      check("busy", busy, eb);
      check("ld_ready", ld_ready, !eb);
      check("instr_ready", instr_ready, !eb);
      check("rd_data", rd_data, rd_exp);
    end
  end

  always @(negedge clock) begin
    if (!hold_rd) rd_reg = AW'($urandom_range(0, NR - 1));
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (!ld_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!ld_ready) check("ready_timeout", ld_ready, 1);
  endtask

  task automatic sched_load(input int idx, input logic [DW-1:0] data, input int a);
    busy_lo = a;
    busy_hi = a;
    if (idx < NR) begin
      wr_cyc = a + 1; wr_idx = idx; wr_val = data;
    end else begin
      err_cyc = a + 1;
    end
  endtask

  task automatic sched_instr(input logic [4:0] op, input int ra, input int rb, input int rc, input int a);
    bit legal;
    legal = (op >= 5'd3) && (op <= 5'd7) && ra < NR && rb < NR && rc < NR;
    busy_lo = a;
    if (legal) begin
      busy_hi = a + 3; done_cyc = a + 4;
      wr_cyc = a + 4; wr_idx = ra; wr_val = m_alu(op, m_read(rb), m_read(rc));
    end else begin
      busy_hi = a + 1; err_cyc = a + 2;
    end
  endtask

  task automatic do_load(input int idx, input logic [DW-1:0] data);
    wait_idle();
    ld_valid = 1; ld_reg = AW'(idx); ld_data = data;
    sched_load(idx, data, cyc + 1);
    @(negedge clock);
    ld_valid = 0;
  endtask

  task automatic do_instr(input logic [4:0] op, input int ra, input int rb, input int rc, output int acc);
    wait_idle();
    instr = {op, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    instr_valid = 1;
    acc = cyc + 1;
    sched_instr(op, ra, rb, rc, acc);
    @(negedge clock);
    instr_valid = 0;
  endtask

  task automatic do_both(input int lidx, input logic [DW-1:0] ldat, input logic [4:0] op,
                         input int ra, input int rb, input int rc);
    wait_idle();
    ld_valid = 1; ld_reg = AW'(lidx); ld_data = ldat;
    instr = {op, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    instr_valid = 1;
    sched_load(lidx, ldat, cyc + 1);
    @(negedge clock);
    ld_valid = 0;
    check("both_instr_waits", instr_ready, 0);
    @(negedge clock);
    sched_instr(op, ra, rb, rc, cyc + 1);
    @(negedge clock);
    instr_valid = 0;
  endtask

  // Waits (bounded) for done or err and pins the edge count since acceptance.
  task automatic wait_pulse(input int acc, input bit want_err, input int lat, input string name);
    int n = 0;
    do begin
      @(posedge clock); #2; n++;
    end while (!(want_err ? err : done) && n < 12);
    check(name, 64'(cyc - acc), 64'(lat));
  endtask

  task automatic pin_rd(input int idx, input logic [DW-1:0] exp, input string name);
    wait_idle();
    hold_rd = 1; rd_reg = AW'(idx);
    @(posedge clock); #2;
    check(name, rd_data, exp);
    hold_rd = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, r;
    logic [4:0] op;
`ifdef R0_ZERO_EN
    r0z = 1;
`else
    r0z = 0;
`endif
    foreach (m_regs[i]) m_regs[i] = '0;
    ld_valid = 0; instr_valid = 0; ld_reg = '0; ld_data = '0; instr = '0; rd_reg = '0;
    #1 clear = 0;
    #1;
    check("init_busy", busy, 0);
    check("init_ready", instr_ready, 1);
    repeat (3) @(negedge clock);
    clear = 1;

    do_load(1, 5);
    do_load(2, 6);
    do_instr(5'b00011, 3, 1, 2, a);
    wait_pulse(a, 0, 4, "add_done_latency");
    pin_rd(3, 32'd11, "add_r3");

    do_load(4, 0);
    do_load(5, 1);
    do_instr(5'b00100, 6, 4, 5, a);
    pin_rd(6, 32'hFFFF_FFFF, "sub_wrap_r6");
    do_load(5, 33);
    do_instr(5'b00111, 7, 1, 5, a);
    pin_rd(7, 32'd10, "shl_mod_r7");

    do_instr(5'b11111, 1, 2, 3, a);
    wait_pulse(a, 1, 2, "illegal_err_latency");
    pin_rd(1, 32'd5, "illegal_r1_kept");
    do_instr(5'b00011, 13, 1, 2, a);
    wait_pulse(a, 1, 2, "bad_index_err_latency");
    do_load(14, 32'h1234);

    do_both(8, 3, 5'b00011, 9, 8, 8);
    pin_rd(9, 32'd6, "both_r9");

    do_load(0, 9);
    pin_rd(0, r0z ? 32'd0 : 32'd9, "r0_after_load");
    do_instr(5'b00011, 0, 1, 2, a);
    wait_pulse(a, 0, 4, "r0_add_done");
    pin_rd(0, r0z ? 32'd0 : 32'd11, "r0_after_add");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        do_load($urandom_range(0, 13), $urandom);
      end else if (r < 8) begin
        op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(3, 7));
        do_instr(op, $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), a);
      end else if (r == 8) begin
        do_both($urandom_range(0, 11), $urandom, 5'($urandom_range(3, 7)),
                $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
      end else begin
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
    end

    do_instr(5'b00011, 3, 1, 2, a);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_busy", busy, 1);
    #1 clear = 0;
    done_cyc = -1; err_cyc = -1; wr_cyc = -1; busy_lo = 1; busy_hi = 0;
    foreach (m_regs[i]) m_regs[i] = '0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_ready", ld_ready, 1);
    repeat (3) @(negedge clock);
    clear = 1;
    repeat (8) @(negedge clock);
    pin_rd(1, 32'd0, "post_reset_r1");
    pin_rd(3, 32'd0, "post_reset_r3");

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
